// File: rtl/traffic_cmd_deser.sv
// Byte-stream command deserializer for the traffic-light controller: assembles
// 5-byte frames (A5, op, hi, lo, chk), validates them and emits command or error strobes.
package definitions_pkg;
    typedef enum logic [2:0] {
        CMD_ON           = 3'd0,
        CMD_OFF          = 3'd1,
        CMD_NOTRANSITION = 3'd2,
        CMD_GREEN_TIME   = 3'd3,
        CMD_RED_TIME     = 3'd4,
        CMD_YELLOW_TIME  = 3'd5
    } command_e;
endpackage

// Handshake: a byte transfers on a rising edge where byte_valid_i && byte_ready_o.
// byte_ready_o is 0 only while in reset, so the upstream link is never stalled.
module traffic_cmd_deser
    import definitions_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE   = 8'hA5,
    parameter int         TIMEOUT_TICKS = 200,
    parameter int         ERR_CNT_W     = 8
) (
    input  logic                 clk_2k_i,
    input  logic                 srst_n_i,
    input  logic [7:0]           byte_data_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    output command_e             cmd_type_o,
    output logic                 cmd_valid_o,
    output logic [15:0]          cmd_data_o,
    output logic                 frame_err_o,
    output logic [1:0]           err_code_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_OPCODE   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GET_OP  = 3'd1,
        S_GET_HI  = 3'd2,
        S_GET_LO  = 3'd3,
        S_GET_CHK = 3'd4
    } state_e;

    state_e                 state_q;
    logic                   byte_ready_q;
    logic [7:0]             op_q;
    logic [7:0]             hi_q;
    logic [7:0]             lo_q;
    logic [TO_W-1:0]        to_cnt_q;
    command_e               cmd_type_q;
    logic                   cmd_valid_q;
    logic [15:0]            cmd_data_q;
    logic                   frame_err_q;
    logic [1:0]             err_code_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    logic                   accept;
    logic                   chk_ok;
    logic                   to_hit;
    logic                   cmd_fire_d;
    logic                   err_fire_d;
    logic [1:0]             err_code_d;

    always_comb begin
        accept     = byte_valid_i && byte_ready_q;
        chk_ok     = (byte_data_i == (op_q ^ hi_q ^ lo_q));
        to_hit     = (to_cnt_q == TO_W'(TIMEOUT_TICKS));
        cmd_fire_d = 1'b0;
        err_fire_d = 1'b0;
        err_code_d = err_code_q;
        // Checksum is judged before the opcode; an accepted byte always beats the timeout.
        if (state_q == S_GET_CHK && accept) begin
            if (!chk_ok) begin
                err_fire_d = 1'b1;
                err_code_d = ERR_CHECKSUM;
            end else if (op_q > 8'd5) begin
                err_fire_d = 1'b1;
                err_code_d = ERR_OPCODE;
            end else begin
                cmd_fire_d = 1'b1;
            end
        end else if (state_q != S_IDLE && !accept && to_hit) begin
            err_fire_d = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_2k_i) begin
        if (!srst_n_i) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            op_q         <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            to_cnt_q     <= '0;
            cmd_type_q   <= CMD_ON;
            cmd_valid_q  <= 1'b0;
            cmd_data_q   <= '0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            byte_ready_q <= 1'b1;
            cmd_valid_q  <= cmd_fire_d;
            frame_err_q  <= err_fire_d;

            if (cmd_fire_d) begin
                cmd_type_q <= command_e'(op_q[2:0]);
                cmd_data_q <= {hi_q, lo_q};
            end

            if (err_fire_d) begin
                err_code_q <= err_code_d;
                if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end

            if (state_q == S_IDLE) begin
                to_cnt_q <= '0;
                if (accept && byte_data_i == HEADER_BYTE) begin
                    state_q <= S_GET_OP;
                end
            end else if (accept) begin
                // Inside a frame every byte is payload, including HEADER_BYTE values.
                to_cnt_q <= '0;
                case (state_q)
                    S_GET_OP: begin
                        op_q    <= byte_data_i;
                        state_q <= S_GET_HI;
                    end
                    S_GET_HI: begin
                        hi_q    <= byte_data_i;
                        state_q <= S_GET_LO;
                    end
                    S_GET_LO: begin
                        lo_q    <= byte_data_i;
                        state_q <= S_GET_CHK;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end else if (to_hit) begin
                state_q  <= S_IDLE;
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign cmd_type_o   = cmd_type_q;
    assign cmd_valid_o  = cmd_valid_q;
    assign cmd_data_o   = cmd_data_q;
    assign frame_err_o  = frame_err_q;
    assign err_code_o   = err_code_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_traffic_cmd_deser.sv
// Directed bench for traffic_cmd_deser: frames driven on negedges, outputs checked
// on the following negedge against hand-computed values.
module tb_traffic_cmd_deser;
    import definitions_pkg::*;

    logic        clk_2k_i;
    logic        srst_n_i;
    logic [7:0]  byte_data_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    command_e    cmd_type_o;
    logic        cmd_valid_o;
    logic [15:0] cmd_data_o;
    logic        frame_err_o;
    logic [1:0]  err_code_o;
    logic [7:0]  err_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cmd   = 0;
    int n_err   = 0;
    int n_both  = 0;

    traffic_cmd_deser dut (
        .clk_2k_i    (clk_2k_i),
        .srst_n_i    (srst_n_i),
        .byte_data_i (byte_data_i),
        .byte_valid_i(byte_valid_i),
        .byte_ready_o(byte_ready_o),
        .cmd_type_o  (cmd_type_o),
        .cmd_valid_o (cmd_valid_o),
        .cmd_data_o  (cmd_data_o),
        .frame_err_o (frame_err_o),
        .err_code_o  (err_code_o),
        .err_cnt_o   (err_cnt_o)
    );

    // clock / reset
    initial clk_2k_i = 1'b0;
    always #5 clk_2k_i = ~clk_2k_i;

    // strobe monitor
    always @(negedge clk_2k_i) begin
        if (cmd_valid_o) n_cmd++;
        if (frame_err_o) n_err++;
        if (cmd_valid_o && frame_err_o) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // drivers: called at a negedge, return at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] b);
        byte_data_i  = b;
        byte_valid_i = 1'b1;
        @(negedge clk_2k_i);
    endtask

    task automatic idle(input int n);
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        repeat (n) @(negedge clk_2k_i);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [7:0] hi,
                              input logic [7:0] lo, input logic [7:0] chk);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(hi);
        send_byte(lo);
        send_byte(chk);
    endtask

    int cmd0, err0, hits;

    initial begin
        srst_n_i     = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        repeat (3) @(negedge clk_2k_i);
        check("rst_ready", 32'(byte_ready_o), 0);
        check("rst_cmd_valid", 32'(cmd_valid_o), 0);
        check("rst_cmd_type", 32'(cmd_type_o), 0);
        check("rst_cmd_data", 32'(cmd_data_o), 0);
        check("rst_err", 32'(frame_err_o), 0);
        check("rst_err_code", 32'(err_code_o), 0);
        check("rst_err_cnt", 32'(err_cnt_o), 0);
        srst_n_i = 1'b1;
        @(negedge clk_2k_i);
        check("ready_after_rst", 32'(byte_ready_o), 1);

        // 1: green time frame
        send_frame(8'h03, 8'h01, 8'hF4, 8'hF6);
        check("t1_valid", 32'(cmd_valid_o), 1);
        check("t1_type", 32'(cmd_type_o), 3);
        check("t1_data", 32'(cmd_data_o), 32'h01F4);
        check("t1_err_cnt", 32'(err_cnt_o), 0);
        idle(1);
        check("t1_valid_one_cycle", 32'(cmd_valid_o), 0);
        check("t1_type_hold", 32'(cmd_type_o), 3);

        // 2: leading junk ignored
        cmd0 = n_cmd; err0 = n_err;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h01, 8'h00, 8'h00, 8'h01);
        check("t2_valid", 32'(cmd_valid_o), 1);
        check("t2_type", 32'(cmd_type_o), 1);
        check("t2_data", 32'(cmd_data_o), 0);
        idle(2);
        check("t2_cmd_pulses", 32'(n_cmd - cmd0), 1);
        check("t2_err_pulses", 32'(n_err - err0), 0);

        // 3: bad checksum then bad opcode
        send_frame(8'h02, 8'h00, 8'h00, 8'h03);
        check("t3_err", 32'(frame_err_o), 1);
        check("t3_code", 32'(err_code_o), 1);
        check("t3_cnt", 32'(err_cnt_o), 1);
        check("t3_no_cmd", 32'(cmd_valid_o), 0);
        idle(1);
        check("t3_err_one_cycle", 32'(frame_err_o), 0);
        check("t3_code_hold", 32'(err_code_o), 1);
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        check("t3_op_err", 32'(frame_err_o), 1);
        check("t3_op_code", 32'(err_code_o), 2);
        check("t3_op_cnt", 32'(err_cnt_o), 2);
        check("t3_type_kept", 32'(cmd_type_o), 1);

        // 4: timeout, then recovery, then byte on the boundary cycle
        idle(2);
        send_byte(8'hA5);
        send_byte(8'h04);
        idle(200);
        check("t4_no_err_yet", 32'(frame_err_o), 0);
        idle(1);
        check("t4_timeout_err", 32'(frame_err_o), 1);
        check("t4_timeout_code", 32'(err_code_o), 3);
        check("t4_timeout_cnt", 32'(err_cnt_o), 3);
        send_frame(8'h04, 8'h00, 8'h0A, 8'h0E);
        check("t4_red_valid", 32'(cmd_valid_o), 1);
        check("t4_red_type", 32'(cmd_type_o), 4);
        check("t4_red_data", 32'(cmd_data_o), 32'h000A);
        idle(1);
        err0 = n_err;
        send_byte(8'hA5);
        send_byte(8'h04);
        idle(200);
        send_byte(8'h00);
        send_byte(8'h0B);
        send_byte(8'h0F);
        check("t4_edge_valid", 32'(cmd_valid_o), 1);
        check("t4_edge_data", 32'(cmd_data_o), 32'h000B);
        idle(2);
        check("t4_edge_no_err", 32'(n_err - err0), 0);
        check("t4_edge_cnt", 32'(err_cnt_o), 3);

        // 5: reset mid-frame
        err0 = n_err;
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h00);
        byte_valid_i = 1'b0;
        srst_n_i = 1'b0;
        @(negedge clk_2k_i);
        check("t5_ready_in_rst", 32'(byte_ready_o), 0);
        check("t5_type_rst", 32'(cmd_type_o), 0);
        check("t5_data_rst", 32'(cmd_data_o), 0);
        check("t5_code_rst", 32'(err_code_o), 0);
        check("t5_cnt_rst", 32'(err_cnt_o), 0);
        srst_n_i = 1'b1;
        @(negedge clk_2k_i);
        check("t5_ready_after", 32'(byte_ready_o), 1);
        send_frame(8'h05, 8'h12, 8'h34, 8'h23);
        check("t5_valid", 32'(cmd_valid_o), 1);
        check("t5_type", 32'(cmd_type_o), 5);
        check("t5_data", 32'(cmd_data_o), 32'h1234);
        check("t5_no_err", 32'(n_err - err0), 0);

        // 6: saturation with back-to-back bad frames
        idle(1);
        err0 = n_err;
        hits = 0;
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h00, 8'h00, 8'h00, 8'h01);
            if (frame_err_o) hits++;
        end
        idle(2);
        check("t6_hits", 32'(hits), 260);
        check("t6_pulses", 32'(n_err - err0), 260);
        check("t6_sat", 32'(err_cnt_o), 255);
        check("t6_code", 32'(err_code_o), 1);
        check("never_both", 32'(n_both), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
